// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, 3-sample majority, byte held on o_valid until i_ack.
// Latency 1325 clk from start edge to o_valid at defaults; a byte arriving while o_valid is unacked is dropped and flagged on o_overrun.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLOCK_MHZ = 16,
  parameter int BAUD_RATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);
  localparam int CLKS_PER_BIT = (CLOCK_MHZ * 1000000 + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [2:0]       hist_q, hist_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_done_q, stop_done_d;
  logic             stop_bit_q, stop_bit_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             maj;
  logic             fall;

  assign maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign fall = rx_prev_q & ~rx_s_q;

  always_comb begin
    rx_meta_d   = i_uart_rx;
    rx_s_d      = rx_meta_q;
    rx_prev_d   = rx_s_q;
    hist_d      = {hist_q[1:0], rx_s_q};
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_done_d = 1'b0;
    stop_bit_d  = stop_bit_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = maj ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {maj, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Stop sample is taken mid stop bit so the next start edge is never missed.
        if (stop_done_q) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          stop_done_d = 1'b1;
          stop_bit_d  = maj;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && i_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // An ack in the delivery cycle frees the holding register for the new byte.
    if (stop_done_q && stop_bit_q) begin
      if (!valid_q || i_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    ferr_d = stop_done_q && !stop_bit_q;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      hist_q      <= 3'b111;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      stop_done_q <= 1'b0;
      stop_bit_q  <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      hist_q      <= hist_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      stop_done_q <= stop_done_d;
      stop_bit_q  <= stop_bit_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames at 139 clk/bit, hand-computed expected bytes and flags.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 139;

  logic       clk;
  logic       i_reset;
  logic       rx_line;
  logic       i_ack;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int n_pass      = 0;
  int n_total     = 0;
  int ferr_cycles = 0;

  uart_rx dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_uart_rx  (rx_line),
    .i_ack      (i_ack),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (o_frame_err === 1'b1) ferr_cycles <= ferr_cycles + 1;

  // Drives start, 8 data bits LSB first, stop; called and returns just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack;
    i_ack = 1'b1;
    @(posedge clk); #1;
    i_ack = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; rx_line = 1'b1; i_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (o_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", o_data); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else n_pass++;
    n_total++; if (o_frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", o_frame_err); else n_pass++;
    n_total++; if (o_overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", o_overrun); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else n_pass++;
    i_reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte;
    int lat;
    int f0;
    lat = 0;
    f0  = ferr_cycles;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (o_valid !== 1'b1 && lat < 3000) begin
          @(posedge clk); #1;
          lat++;
        end
        n_total++; if (lat < 1323 || lat > 1327) $display("FAIL single_latency: got %0d expected 1325+-2", lat); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL single_busy_at_valid: got %b expected 0", o_busy); else n_pass++;
      end
    join
    n_total++; if (o_data !== 8'hA5) $display("FAIL single_data: got %h expected a5", o_data); else n_pass++;
    n_total++; if (ferr_cycles != f0) $display("FAIL single_frame_err: got %0d pulses expected 0", ferr_cycles - f0); else n_pass++;
    pulse_ack();
    n_total++; if (o_valid !== 1'b0) $display("FAIL single_ack_clear: got %b expected 0", o_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          int w;
          w = 0;
          while (o_valid !== 1'b1 && w < 3000) begin
            @(posedge clk); #1;
            w++;
          end
          n_total++; if (o_valid !== 1'b1) $display("FAIL b2b_timeout_%0d: got valid %b expected 1", k, o_valid); else n_pass++;
          n_total++; if (o_data !== exp_b[k]) $display("FAIL b2b_data_%0d: got %h expected %h", k, o_data, exp_b[k]); else n_pass++;
          n_total++; if (o_overrun !== 1'b0) $display("FAIL b2b_overrun_%0d: got %b expected 0", k, o_overrun); else n_pass++;
          pulse_ack();
        end
      end
    join
    n_total++; if (o_valid !== 1'b0) $display("FAIL b2b_final_valid: got %b expected 0", o_valid); else n_pass++;
  endtask

  task automatic test_overrun;
    send_frame(8'h12, 1'b1);
    n_total++; if (o_overrun !== 1'b0) $display("FAIL ovr_first_overrun: got %b expected 0", o_overrun); else n_pass++;
    send_frame(8'h34, 1'b1);
    n_total++; if (o_data !== 8'h12) $display("FAIL ovr_data_kept: got %h expected 12", o_data); else n_pass++;
    n_total++; if (o_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", o_valid); else n_pass++;
    n_total++; if (o_overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", o_overrun); else n_pass++;
    pulse_ack();
    n_total++; if (o_valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b expected 0", o_valid); else n_pass++;
    n_total++; if (o_overrun !== 1'b0) $display("FAIL ovr_ack_clear: got %b expected 0", o_overrun); else n_pass++;
  endtask

  task automatic test_ack_on_delivery;
    send_frame(8'h6B, 1'b1);
    n_total++; if (o_data !== 8'h6B) $display("FAIL sim_first_data: got %h expected 6b", o_data); else n_pass++;
    // Second byte is handed over on the 1324th edge after its start edge; ack lands on exactly that edge.
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (1324) @(posedge clk);
        #1;
        i_ack = 1'b1;
        @(posedge clk); #1;
        i_ack = 1'b0;
        n_total++; if (o_data !== 8'hC3) $display("FAIL sim_data: got %h expected c3", o_data); else n_pass++;
        n_total++; if (o_overrun !== 1'b0) $display("FAIL sim_overrun: got %b expected 0", o_overrun); else n_pass++;
      end
    join
    n_total++; if (o_valid !== 1'b1) $display("FAIL sim_valid_held: got %b expected 1", o_valid); else n_pass++;
    pulse_ack();
    n_total++; if (o_valid !== 1'b0) $display("FAIL sim_ack_clear: got %b expected 0", o_valid); else n_pass++;
  endtask

  task automatic test_glitch;
    int f0;
    f0 = ferr_cycles;
    rx_line = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (o_busy !== 1'b1) $display("FAIL glitch_busy_rise: got %b expected 1", o_busy); else n_pass++;
    repeat (30) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL glitch_busy_fall: got %b expected 0", o_busy); else n_pass++;
    repeat (300) @(posedge clk);
    #1;
    n_total++; if (o_valid !== 1'b0) $display("FAIL glitch_no_valid: got %b expected 0", o_valid); else n_pass++;
    n_total++; if (ferr_cycles != f0) $display("FAIL glitch_no_ferr: got %0d pulses expected 0", ferr_cycles - f0); else n_pass++;
  endtask

  task automatic test_frame_error;
    int f0;
    f0 = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    repeat (2000) @(posedge clk);
    #1;
    n_total++; if (ferr_cycles - f0 != 1) $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cycles - f0); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL ferr_no_valid: got %b expected 0", o_valid); else n_pass++;
    n_total++; if (o_data !== 8'hC3) $display("FAIL ferr_data_kept: got %h expected c3", o_data); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL ferr_low_line_busy: got %b expected 0", o_busy); else n_pass++;
    rx_line = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1);
    n_total++; if (o_valid !== 1'b1) $display("FAIL ferr_next_valid: got %b expected 1", o_valid); else n_pass++;
    n_total++; if (o_data !== 8'h81) $display("FAIL ferr_next_data: got %h expected 81", o_data); else n_pass++;
    n_total++; if (ferr_cycles - f0 != 1) $display("FAIL ferr_next_clean: got %0d cycles expected 1", ferr_cycles - f0); else n_pass++;
  endtask

  task automatic test_mid_frame_reset;
    logic [9:0] bits;
    bits = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_line = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_line = bits[5];
    repeat (70) @(posedge clk);
    #1;
    n_total++; if (o_busy !== 1'b1) $display("FAIL mrst_busy_before: got %b expected 1", o_busy); else n_pass++;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    n_total++; if (o_data !== 8'h00) $display("FAIL mrst_data: got %h expected 00", o_data); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL mrst_valid: got %b expected 0", o_valid); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL mrst_busy: got %b expected 0", o_busy); else n_pass++;
    n_total++; if (o_overrun !== 1'b0) $display("FAIL mrst_overrun: got %b expected 0", o_overrun); else n_pass++;
    n_total++; if (o_frame_err !== 1'b0) $display("FAIL mrst_frame_err: got %b expected 0", o_frame_err); else n_pass++;
    repeat (1600) @(posedge clk);
    #1;
    n_total++; if (o_valid !== 1'b0) $display("FAIL mrst_no_delivery: got %b expected 0", o_valid); else n_pass++;
    send_frame(8'hE7, 1'b1);
    n_total++; if (o_valid !== 1'b1) $display("FAIL mrst_next_valid: got %b expected 1", o_valid); else n_pass++;
    n_total++; if (o_data !== 8'hE7) $display("FAIL mrst_next_data: got %h expected e7", o_data); else n_pass++;
  endtask

  initial begin
    i_reset = 1'b1;
    rx_line = 1'b1;
    i_ack   = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_ack_on_delivery();
    test_glitch();
    test_frame_error();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the serial transmit path.
- Samples the asynchronous i_uart_rx pin, recovers bytes LSB-first, and presents each byte on a valid/ack holding register.
- Sits beside uart_tx at top level and feeds a byte consumer (loopback/echo logic, command parser).
- Derives bit timing directly from i_clk; no uart_clock instance is needed.

Parameters:
- CLOCK_MHZ, 16, system clock frequency in MHz.
- BAUD_RATE, 115200, line rate in bits/s.
- CLKS_PER_BIT (localparam), derived as round(CLOCK_MHZ*1e6/BAUD_RATE); 139 at the defaults.
- HALF_BIT (localparam), derived as CLKS_PER_BIT/2 (integer division); 69 at the defaults.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_uart_rx  input  1  asynchronous serial line; idles high.
- i_ack  input  1  consumer has taken o_data; only meaningful while o_valid=1.
- o_data  output  8  last received byte.
- o_valid  output  1  o_data holds an unconsumed byte.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  a byte was dropped because o_valid was still set.
- o_busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset values:
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Two-flop synchronizer and edge-history flop reset to 1; 3-bit majority shift register reset to 3'b111.
  - State=IDLE, bit counter=0, clock counter=0.
- Input path:
  - i_uart_rx passes through a 2-flop synchronizer, giving rx_s.
  - rx_s shifts into a 3-bit history each cycle.
  - maj = majority of the 3 history bits.
- State machine, one clock counter (width = clog2(CLKS_PER_BIT)):
  - IDLE: on rx_s=0 with previous rx_s=1 (falling edge), go to START and clear the counter. A line held low, e.g. a break or low out of reset, never triggers; it needs a high-to-low transition.
  - START: counter increments. At counter==HALF_BIT, evaluate maj:
    - maj=1: false start, go to IDLE.
    - maj=0: go to DATA, clear the counter and the bit index.
  - DATA: at counter==CLKS_PER_BIT-1, shift maj into the shift register (LSB first), clear the counter, increment the bit index. After the 8th bit, go to STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample maj, then go to IDLE the next cycle.
    - maj=1: deliver the byte.
    - maj=0: pulse o_frame_err for 1 cycle; the byte is discarded and o_valid/o_data are unchanged.
- Sample points land at bit centres, offset 1 cycle by the majority window. Evaluation happens during the stop bit, so back-to-back frames (next start bit immediately after the stop bit) are received without loss.
- Delivery, in the cycle after the stop sample:
  - o_valid=0: load o_data and set o_valid=1.
  - o_valid=1 and i_ack=1 in that same cycle: load the new byte, keep o_valid=1, do not set o_overrun.
  - o_valid=1 and i_ack=0: keep the old o_data, drop the new byte, set o_overrun.
- Ack handling:
  - i_ack=1 while o_valid=1 (and no simultaneous delivery) clears o_valid the next cycle.
  - i_ack=1 while o_valid=1 clears o_overrun.
  - i_ack while o_valid=0 is ignored.
- o_busy = (state != IDLE), registered.
- Latency from the i_uart_rx falling edge to o_valid rising is 2 (sync) + 1 + HALF_BIT + 9*CLKS_PER_BIT + 2 cycles, i.e. 1325 at the defaults. The bench tolerates ±2 cycles.
- Reset mid-frame aborts the frame with no partial delivery; all outputs return to their reset values the next cycle.

Test Plan:
- Drive 0xA5 at 115200 (139 clk/bit), 8N1 -> o_valid rises 1325±2 clk after the start edge; o_data=0xA5; o_frame_err=0; o_busy falls during the stop bit.
- Three back-to-back bytes 0x00, 0xFF, 0x55 with i_ack pulsed on each o_valid -> three deliveries in order; no o_overrun.
- Bytes 0x12 then 0x34 with no i_ack -> o_data stays 0x12 and o_overrun=1. Then i_ack -> o_valid=0, o_overrun=0.
- i_ack asserted in the exact cycle the second byte is delivered -> o_data=new byte, o_valid stays 1, o_overrun=0.
- Low glitch of 40 clk on an idle line -> no delivery; o_busy returns to 0 by cycle ~72.
- Frame 0x3C with stop bit driven low -> single-cycle o_frame_err, no o_valid. With the line then held low 2000 clk and released, no spurious start; the next valid frame 0x81 is received correctly.
- i_reset pulsed mid-data-bit 4 of a frame -> outputs go to reset values, no delivery; the following frame is received correctly.
